// File: rtl/spi_slave_sync.sv
// spi_slave_sync: SPI slave running entirely in the system clock domain.
// SCLK, MOSI and SS are oversampled through SYNC_STAGES flops. All four
// CPOL/CPHA modes are supported, with a full-duplex MISO path fed from a
// one-word TX holding buffer, back-to-back words and abort detection.
// Ports:
//   i_clk, i_rst_n       system clock, asynchronous active-low reset
//   i_sclk, i_mosi, i_ss SPI bus from master (asynchronous, SS active low)
//   o_miso, o_miso_oe    slave-out data and its output enable
//   o_rx_data/o_rx_valid last received word / 1-cycle update pulse
//   i_tx_data/i_tx_load  next word to transmit / write strobe
//   o_tx_ready           TX holding buffer empty
//   o_tx_underrun        1-cycle pulse: word started with empty buffer
//   o_frame_err          1-cycle pulse: SS released mid-word
//   o_busy               frame in progress
module spi_slave_sync #(
  parameter int WIDTH       = 8,
  parameter int CPOL        = 0,
  parameter int CPHA        = 0,
  parameter int MSB_FIRST   = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_sclk,
  input  logic             i_mosi,
  input  logic             i_ss,
  output logic             o_miso,
  output logic             o_miso_oe,
  output logic [WIDTH-1:0] o_rx_data,
  output logic             o_rx_valid,
  input  logic [WIDTH-1:0] i_tx_data,
  input  logic             i_tx_load,
  output logic             o_tx_ready,
  output logic             o_tx_underrun,
  output logic             o_frame_err,
  output logic             o_busy
);

  localparam int             CW        = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST_BIT  = CW'(WIDTH - 1);
  localparam logic           SCLK_IDLE = (CPOL != 0);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t r_state, w_state_next;

  // Synchronisers and edge-detect history
  logic [SYNC_STAGES-1:0] r_sclk_sync, r_mosi_sync, r_ss_sync, r_warm;
  logic                   r_sclk_prev, r_ss_prev, r_armed;
  logic                   w_sclk, w_mosi, w_ss;
  logic                   w_sclk_rise, w_sclk_fall, w_lead, w_trail;
  logic                   w_sample_edge, w_shift_edge;
  logic                   w_ss_fall, w_ss_rise;

  // Datapath
  logic [CW-1:0]    r_bitcnt;
  logic [WIDTH-1:0] r_rx_shift, r_rx_data, r_tx_shift, r_tx_buf;
  logic [WIDTH-1:0] w_rx_next, w_tx_adv;
  logic             r_tx_full, r_rx_valid, r_underrun, r_frame_err;

  // Control strobes
  logic w_start, w_sample_en, w_shift_en, w_abort, w_word_done, w_word_start;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sclk_sync <= {SYNC_STAGES{SCLK_IDLE}};
      r_mosi_sync <= '0;
      r_ss_sync   <= '1;
      r_warm      <= '0;
      r_sclk_prev <= SCLK_IDLE;
      r_ss_prev   <= 1'b1;
      r_armed     <= 1'b0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], i_sclk};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], i_mosi};
      r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0], i_ss};
      r_warm      <= {r_warm[SYNC_STAGES-2:0], 1'b1};
      r_sclk_prev <= w_sclk;
      r_ss_prev   <= w_ss;
      // Frames may only start after a genuine (post-reset) SS-high sample,
      // so an SS held low across reset release does not open a frame.
      if (r_warm[SYNC_STAGES-1] && w_ss) r_armed <= 1'b1;
    end
  end

  assign w_sclk = r_sclk_sync[SYNC_STAGES-1];
  assign w_mosi = r_mosi_sync[SYNC_STAGES-1];
  assign w_ss   = r_ss_sync[SYNC_STAGES-1];

  assign w_sclk_rise   = w_sclk & ~r_sclk_prev;
  assign w_sclk_fall   = ~w_sclk & r_sclk_prev;
  assign w_lead        = (CPOL == 0) ? w_sclk_rise : w_sclk_fall;
  assign w_trail       = (CPOL == 0) ? w_sclk_fall : w_sclk_rise;
  assign w_sample_edge = (CPHA == 0) ? w_lead : w_trail;
  assign w_shift_edge  = (CPHA == 0) ? w_trail : w_lead;
  assign w_ss_fall     = r_ss_prev & ~w_ss & r_armed;
  assign w_ss_rise     = ~r_ss_prev & w_ss;

  // FSM: state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_state_next;
  end

  // FSM: next state
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_ss_fall) w_state_next = ACTIVE;
      ACTIVE:  if (w_ss_rise) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // FSM: outputs / control strobes.
  // Shift edges with bitcnt==0 never advance the TX register: in CPHA=1 this
  // is the first leading edge of a word, in CPHA=0 it is the trailing edge
  // right after a word boundary, where the fresh word must keep its bit 0.
  always_comb begin
    w_start     = 1'b0;
    w_sample_en = 1'b0;
    w_shift_en  = 1'b0;
    w_abort     = 1'b0;
    case (r_state)
      IDLE: w_start = w_ss_fall;
      ACTIVE: begin
        if (w_ss_rise) begin
          w_abort = (r_bitcnt != '0);
        end else begin
          w_sample_en = w_sample_edge;
          w_shift_en  = w_shift_edge && (r_bitcnt != '0);
        end
      end
      default: ;
    endcase
  end

  assign w_word_done  = w_sample_en && (r_bitcnt == LAST_BIT);
  assign w_word_start = w_start || w_word_done;

  assign w_rx_next = (MSB_FIRST != 0) ? {r_rx_shift[WIDTH-2:0], w_mosi}
                                      : {w_mosi, r_rx_shift[WIDTH-1:1]};
  assign w_tx_adv  = (MSB_FIRST != 0) ? {r_tx_shift[WIDTH-2:0], 1'b1}
                                      : {1'b1, r_tx_shift[WIDTH-1:1]};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_bitcnt    <= '0;
      r_rx_shift  <= '0;
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_tx_shift  <= '0;
      r_tx_buf    <= '0;
      r_tx_full   <= 1'b0;
      r_underrun  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_rx_valid  <= 1'b0;
      r_underrun  <= 1'b0;
      r_frame_err <= w_abort;

      if (w_start) r_bitcnt <= '0;

      if (w_sample_en) begin
        r_rx_shift <= w_rx_next;
        if (w_word_done) begin
          r_bitcnt   <= '0;
          r_rx_data  <= w_rx_next;
          r_rx_valid <= 1'b1;
        end else begin
          r_bitcnt <= r_bitcnt + CW'(1);
        end
      end

      if (w_word_start) begin
        if (r_tx_full) begin
          r_tx_shift <= r_tx_buf;
          r_tx_full  <= 1'b0;
        end else if (i_tx_load) begin
          // Load coinciding with word start on an empty buffer goes straight out.
          r_tx_shift <= i_tx_data;
        end else begin
          r_tx_shift <= '1;
          r_underrun <= 1'b1;
        end
      end else begin
        if (w_shift_en) r_tx_shift <= w_tx_adv;
        if (i_tx_load && !r_tx_full) begin
          r_tx_buf  <= i_tx_data;
          r_tx_full <= 1'b1;
        end
      end
    end
  end

  assign o_miso        = (MSB_FIRST != 0) ? r_tx_shift[WIDTH-1] : r_tx_shift[0];
  assign o_miso_oe     = ~w_ss;
  assign o_rx_data     = r_rx_data;
  assign o_rx_valid    = r_rx_valid;
  assign o_tx_ready    = ~r_tx_full;
  assign o_tx_underrun = r_underrun;
  assign o_frame_err   = r_frame_err;
  assign o_busy        = (r_state == ACTIVE);

endmodule
